mem_port_arbiter: RTL

- Shares one single-port synchronous memory between the IF-stage instruction fetch and the MEM-stage load/store unit. Only one transaction is outstanding at a time.
- Data accesses win by default. A starvation counter guarantees fetch progress.
- Returns each response to its owner after a fixed memory latency. Supports killing an in-flight fetch when the pipeline flushes on a branch or BTB mispredict.

---
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM shared single-port memory arbiter with starvation guard and fetch kill
module mem_port_arbiter #(
  parameter int Width     = 32,
  parameter int MemLat    = 1,
  parameter int StarveMax = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             if_req_i,
  input  logic [Width-1:0] if_addr_i,
  input  logic             if_kill_i,
  output logic             if_gnt_o,
  output logic             if_rvalid_o,
  output logic [Width-1:0] if_rdata_o,
  input  logic             d_req_i,
  input  logic             d_we_i,
  input  logic [3:0]       d_be_i,
  input  logic [Width-1:0] d_addr_i,
  input  logic [Width-1:0] d_wdata_i,
  output logic             d_gnt_o,
  output logic             d_rvalid_o,
  output logic [Width-1:0] d_rdata_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [3:0]       mem_be_o,
  output logic [Width-1:0] mem_addr_o,
  output logic [Width-1:0] mem_wdata_o,
  input  logic [Width-1:0] mem_rdata_i,
  output logic             busy_o
);

  localparam int LatW = $clog2(MemLat + 1);
  localparam int StW  = $clog2(StarveMax + 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } owner_e;

  state_e          state_q;
  owner_e          owner_q;
  logic [LatW-1:0] lat_q;
  logic [StW-1:0]  starve_q;
  logic            kill_q;

  logic eligible;
  logic resp;
  logic grant_if;
  logic grant_d;

  // Outputs are gated by rst_ni so they read zero for the whole reset window.
  assign eligible = rst_ni && ((state_q == IDLE) || (lat_q == LatW'(1)));
  assign resp     = rst_ni && (state_q == BUSY) && (lat_q == LatW'(1));
  assign grant_if = eligible && if_req_i && (!d_req_i || (starve_q == StW'(StarveMax)));
  assign grant_d  = eligible && d_req_i && !grant_if;

  assign if_gnt_o = grant_if;
  assign d_gnt_o  = grant_d;
  assign busy_o   = (state_q == BUSY);

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (grant_if) begin
      mem_req_o  = 1'b1;
      mem_be_o   = 4'hF;
      mem_addr_o = if_addr_i;
    end else if (grant_d) begin
      mem_req_o   = 1'b1;
      mem_we_o    = d_we_i;
      mem_be_o    = d_be_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end
  end

  // A kill arriving in the response cycle itself still suppresses that response.
  assign if_rvalid_o = resp && (owner_q == OWN_IF) && !kill_q && !if_kill_i;
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign d_rvalid_o  = resp && (owner_q == OWN_D);
  assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      lat_q    <= '0;
      starve_q <= '0;
      kill_q   <= 1'b0;
    end else begin
      if (grant_if || grant_d) begin
        state_q <= BUSY;
        lat_q   <= LatW'(MemLat);
        owner_q <= grant_if ? OWN_IF : OWN_D;
        kill_q  <= 1'b0;
      end else if (state_q == BUSY) begin
        if (lat_q == LatW'(1)) begin
          state_q <= IDLE;
          owner_q <= OWN_NONE;
          lat_q   <= '0;
        end else begin
          lat_q <= lat_q - LatW'(1);
        end
        if ((owner_q == OWN_IF) && if_kill_i) begin
          kill_q <= 1'b1;
        end
      end

      if (grant_if) begin
        starve_q <= '0;
      end else if (grant_d && if_req_i && (starve_q != StW'(StarveMax))) begin
        starve_q <= starve_q + StW'(1);
      end
    end
  end

endmodule
